pattern_check_arbiter: RTL and testbench
========================================

Name: pattern_check_arbiter

Overview:
- Shares one serial 5-bit pattern checker (default pattern 11011, overlapping matches) between two requesters.
- Each requester offers an 8-bit word. The block arbitrates round-robin, latches the winning word and shifts it MSB-first through the checker, one bit per clock.
- At the end of the word it reports the match count and the requester id.
- Sits between the parallel data producers and the serial check datapath.

Parameters:
- WORD_W, 8: bits per request word; the block is shifted MSB-first.
- PAT_W, 5: pattern length in bits.
- PAT, 5'b11011: pattern compared against the most recent PAT_W serial bits. The newest bit is the LSB of the comparison.
- CNT_W, 4: width of match_cnt. Must satisfy 2^CNT_W > WORD_W-PAT_W+1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  2  request per requester. Held high, with its word stable, until the matching gnt bit pulses.
- word0  in  WORD_W  data for requester 0.
- word1  in  WORD_W  data for requester 1.
- gnt  out  2  one-hot, single-cycle acceptance pulse.
- busy  out  1  high from the grant cycle through the done cycle, inclusive.
- ser_bit  out  1  bit currently presented to the checker.
- ser_vld  out  1  high while ser_bit is valid.
- done  out  1  single-cycle completion pulse.
- done_id  out  1  requester served; valid when done=1, held afterwards.
- match_cnt  out  CNT_W  number of pattern matches in the word; valid when done=1, held until the next done.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - gnt, busy, ser_bit, ser_vld, done, done_id and match_cnt all 0.
  - Round-robin pointer favours requester 0.
  - Checker history and counters cleared.
  - Applies from any state, including mid-shift; the word in progress is discarded and no done is issued.
- FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - If req!=0 at an edge, select a winner:
    - If only one bit of req is set, that requester wins.
    - If both are set, the requester favoured by the pointer wins.
  - On that edge:
    - latch the winner's word into the shift register;
    - set gnt[winner]=1 for one cycle;
    - clear history, match counter and bit index;
    - go to SHIFT.
  - If req=0, stay in IDLE.
- Pointer update: after a grant to i, the pointer favours 1-i.
- SHIFT, WORD_W cycles:
  - Cycle k (k=0..WORD_W-1): ser_vld=1 and ser_bit = latched word bit [WORD_W-1-k].
  - The first SHIFT cycle coincides with the gnt pulse.
  - Each cycle, shift ser_bit into a PAT_W-bit history register.
  - A match is counted when the updated history equals PAT and at least PAT_W bits of the current word have been shifted, i.e. k>=PAT_W-1.
  - Overlapping matches all count.
  - History never spans two words.
  - After cycle WORD_W-1, go to REPORT.
- REPORT, 1 cycle:
  - done=1, done_id=winner, match_cnt=final count, ser_vld=0.
  - Then go to IDLE.
- Latency:
  - req is sampled at edge E0.
  - gnt and the first serial bit appear in the cycle after E0.
  - done is high in the cycle after the last serial bit, i.e. WORD_W+1 cycles after E0.
  - IDLE is re-entered one cycle later.
  - Minimum spacing between grants: WORD_W+2 cycles.
- Requests arriving while busy wait; they are not lost as long as req is held.
- req deasserted before its grant: withdrawn, no effect.
- match_cnt saturates at 2^CNT_W-1. This is unreachable with legal parameters.

Test Plan:
- Reset, then req=2'b01, word0=8'hDB (11011011) → gnt=01 for 1 cycle; ser_bit sequence 1,1,0,1,1,0,1,1; done after 9 cycles with done_id=0, match_cnt=2.
- req=2'b10, word1=8'h00 → done_id=1, match_cnt=0. Then word1=8'hD8 → match_cnt=1.
- req=2'b11 held continuously, word0=8'hDB, word1=8'hD8 → grants alternate 0,1,0,1, spaced exactly 10 cycles apart; each done reports the matching id and count (2 / 1).
- Cross-word isolation: word0=8'h03 served, then word1=8'h60 → both match_cnt=0, with no match across the word boundary.
- Assert rst for 1 cycle during SHIFT bit 4 → next cycle all outputs 0; no done for that word; with req=2'b11, the next grant goes to requester 0.
- Assert req=2'b10 while busy serving requester 0 → gnt[1] arrives exactly 1 cycle after done falls; req withdrawn before its grant → no grant.

Source files
------------

// File: rtl/pattern_check_arbiter.sv
// pattern_check_arbiter
// Two requesters share one serial pattern checker. A round-robin arbiter
// picks a winner, its word is shifted MSB-first through a PAT_W-bit history
// window, and overlapping matches of PAT are counted. A single-cycle done
// pulse reports the count and the id of the requester that was served.
module pattern_check_arbiter #(
  parameter int                 WORD_W = 8,
  parameter int                 PAT_W  = 5,
  parameter logic [PAT_W-1:0]   PAT    = 5'b11011,
  parameter int                 CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [WORD_W-1:0] word0,
  input  logic [WORD_W-1:0] word1,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              ser_bit,
  output logic              ser_vld,
  output logic              done,
  output logic              done_id,
  output logic [CNT_W-1:0]  match_cnt
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  sr_q, sr_d;         // latched word, MSB is the bit on ser_bit
  logic [PAT_W-2:0]   hist_q, hist_d;     // older PAT_W-1 bits; ser_bit completes the window
  logic [IDX_W-1:0]   idx_q, idx_d;       // index k of the bit currently presented
  logic [CNT_W-1:0]   cnt_q, cnt_d;       // running match count for the current word
  logic               ptr_q, ptr_d;       // requester favoured on a tie
  logic               win_q, win_d;       // requester currently being served
  logic [1:0]         gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               ser_bit_q, ser_bit_d;
  logic               ser_vld_q, ser_vld_d;
  logic               done_q, done_d;
  logic               done_id_q, done_id_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;

  logic [PAT_W-1:0]   window_s;
  logic               winner_s;

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign ser_bit   = ser_bit_q;
  assign ser_vld   = ser_vld_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign match_cnt = match_cnt_q;

  // Next-state and output logic: arbitration, serial shifting, match counting.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    hist_d      = hist_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    gnt_d       = 2'b00;
    busy_d      = busy_q;
    ser_bit_d   = 1'b0;
    ser_vld_d   = 1'b0;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    match_cnt_d = match_cnt_q;
    window_s    = {hist_q, ser_bit_q};
    winner_s    = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (req != 2'b00) begin
          // A lone request wins outright; a tie goes to the favoured side.
          if (req == 2'b11) begin
            winner_s = ptr_q;
          end else begin
            winner_s = req[1];
          end
          win_d     = winner_s;
          sr_d      = winner_s ? word1 : word0;
          gnt_d     = winner_s ? 2'b10 : 2'b01;
          busy_d    = 1'b1;
          ser_bit_d = sr_d[WORD_W-1];
          ser_vld_d = 1'b1;
          hist_d    = '0;
          idx_d     = '0;
          cnt_d     = '0;
          ptr_d     = ~winner_s;
          state_d   = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        // History is cleared at grant, so the window never spans two words.
        hist_d = window_s[PAT_W-2:0];
        if ((window_s == PAT) && (idx_q >= IDX_W'(PAT_W-1)) && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
        if (idx_q == IDX_W'(WORD_W-1)) begin
          done_d      = 1'b1;
          done_id_d   = win_q;
          match_cnt_d = cnt_d;
          state_d     = REPORT;
        end else begin
          sr_d      = {sr_q[WORD_W-2:0], 1'b0};
          idx_d     = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
          ser_bit_d = sr_d[WORD_W-1];
          ser_vld_d = 1'b1;
          state_d   = SHIFT;
        end
      end

      REPORT: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      hist_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      win_q       <= 1'b0;
      gnt_q       <= 2'b00;
      busy_q      <= 1'b0;
      ser_bit_q   <= 1'b0;
      ser_vld_q   <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      hist_q      <= hist_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      ser_bit_q   <= ser_bit_d;
      ser_vld_q   <= ser_vld_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
    end
  end

endmodule

// File: tb/tb_pattern_check_arbiter.sv
// Self-checking bench for pattern_check_arbiter: directed scenarios followed
// by random requests, checked against a word-level reference model.
module tb_pattern_check_arbiter;

  localparam int WORD_W = 8;
  localparam int PAT_W  = 5;
  localparam logic [4:0] PAT_REF = 5'b11011;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [7:0] word0, word1;
  logic [1:0] gnt;
  logic       busy, ser_bit, ser_vld, done, done_id;
  logic [3:0] match_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ptr_m = 0;          // model of the round-robin preference
  int last_gnt_cyc = 0;
  int last_done_cyc = 0;

  pattern_check_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .word0(word0), .word1(word1),
    .gnt(gnt), .busy(busy), .ser_bit(ser_bit), .ser_vld(ser_vld),
    .done(done), .done_id(done_id), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count windows of PAT_W consecutive bits (MSB first) that equal the pattern.
  function automatic int ref_count(input logic [7:0] w);
    int n;
    logic [7:0] sh;
    n = 0;
    for (int k = PAT_W - 1; k < WORD_W; k++) begin
      sh = w >> (WORD_W - 1 - k);
      if (sh[4:0] == PAT_REF) n++;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, {30'd0, gnt}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ser_bit"}, {31'd0, ser_bit}, 32'd0);
    chk({tag, "_ser_vld"}, {31'd0, ser_vld}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_done_id"}, {31'd0, done_id}, 32'd0);
    chk({tag, "_match_cnt"}, {28'd0, match_cnt}, 32'd0);
  endtask

  // One full transaction: request, grant, 8 serial bits, done, back to idle.
  // gap_gnt>0 checks spacing from the previous grant; gap_done>0 from the previous done.
  task automatic serve(input logic [1:0] r, input logic [7:0] w0, input logic [7:0] w1,
                       input bit keep, input int gap_gnt, input int gap_done,
                       input logic [1:0] late_req, input logic [1:0] late_drop,
                       output int win);
    bit got;
    int ew;
    logic [7:0] w;
    req = r; word0 = w0; word1 = w1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) got = 1'b1;
    end
    chk("gnt_seen", {31'd0, got}, 32'd1);
    ew = (r == 2'b11) ? ptr_m : ((r == 2'b10) ? 1 : 0);
    ptr_m = 1 - ew;
    win = ew;
    w = (ew == 1) ? w1 : w0;
    chk("gnt_onehot", {30'd0, gnt}, (ew == 1) ? 32'd2 : 32'd1);
    chk("busy_at_gnt", {31'd0, busy}, 32'd1);
    chk("ser_vld_bit0", {31'd0, ser_vld}, 32'd1);
    chk("ser_bit0", {31'd0, ser_bit}, {31'd0, w[7]});
    if (gap_gnt > 0) chk("gnt_spacing", cyc - last_gnt_cyc, gap_gnt);
    if (gap_done > 0) chk("gnt_after_done", cyc - last_done_cyc, gap_done);
    last_gnt_cyc = cyc;
    if (!keep) req[ew] = 1'b0;
    for (int k = 1; k < WORD_W; k++) begin
      @(negedge clk);
      if (k == 3) req = req | late_req;
      if (k == 5) req = req & ~late_drop;
      chk("ser_bit", {31'd0, ser_bit}, {31'd0, w[7-k]});
      chk("ser_vld", {31'd0, ser_vld}, 32'd1);
      chk("gnt_pulse", {30'd0, gnt}, 32'd0);
      chk("no_early_done", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    chk("done", {31'd0, done}, 32'd1);
    chk("done_id", {31'd0, done_id}, ew);
    chk("match_cnt", {28'd0, match_cnt}, ref_count(w));
    chk("ser_vld_report", {31'd0, ser_vld}, 32'd0);
    chk("busy_report", {31'd0, busy}, 32'd1);
    last_done_cyc = cyc;
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("match_cnt_hold", {28'd0, match_cnt}, ref_count(w));
  endtask

  initial begin
    int win;
    bit saw_done;
    logic [1:0] r;
    logic [7:0] rw0, rw1;

    rst = 1'b1; req = 2'b00; word0 = 8'h00; word1 = 8'h00;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic serving of each requester.
    serve(2'b01, 8'hDB, 8'h00, 1'b0, 0, 0, 2'b00, 2'b00, win);
    serve(2'b10, 8'h00, 8'h00, 1'b0, 0, 0, 2'b00, 2'b00, win);
    serve(2'b10, 8'h00, 8'hD8, 1'b0, 0, 0, 2'b00, 2'b00, win);

    // Continuous tie: grants alternate, spaced WORD_W+2 cycles.
    req = 2'b00; ptr_m = 0;  // pointer favours 0 after last grant to 1
    serve(2'b11, 8'hDB, 8'hD8, 1'b1, 0, 0, 2'b00, 2'b00, win);
    chk("rr_first", win, 0);
    serve(2'b11, 8'hDB, 8'hD8, 1'b1, 10, 0, 2'b00, 2'b00, win);
    chk("rr_second", win, 1);
    serve(2'b11, 8'hDB, 8'hD8, 1'b1, 10, 0, 2'b00, 2'b00, win);
    chk("rr_third", win, 0);
    serve(2'b11, 8'hDB, 8'hD8, 1'b0, 10, 0, 2'b00, 2'b00, win);
    chk("rr_fourth", win, 1);
    req = 2'b00;

    // Cross-word isolation.
    serve(2'b01, 8'h03, 8'h60, 1'b0, 0, 0, 2'b00, 2'b00, win);
    serve(2'b10, 8'h03, 8'h60, 1'b0, 0, 0, 2'b00, 2'b00, win);

    // Reset during bit 4 of a shift.
    req = 2'b01; word0 = 8'hDB;
    for (int i = 0; i < 20 && gnt == 2'b00; i++) @(negedge clk);
    chk("rst_test_gnt", {30'd0, gnt}, 32'd1);
    req = 2'b00;
    repeat (4) @(negedge clk);
    chk("bit4_before_rst", {31'd0, ser_bit}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
    chk_all_zero("midshift_rst");
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("no_done_after_rst", {31'd0, saw_done}, 32'd0);
    serve(2'b11, 8'hDB, 8'hD8, 1'b0, 0, 0, 2'b00, 2'b00, win);
    chk("rr_after_rst", win, 0);
    req = 2'b00;

    // Request arriving while busy waits for exactly one cycle after done falls.
    serve(2'b01, 8'hDB, 8'hD8, 1'b0, 0, 0, 2'b10, 2'b00, win);
    serve(2'b10, 8'hDB, 8'hD8, 1'b0, 0, 2, 2'b00, 2'b00, win);
    req = 2'b00;

    // Request withdrawn before its grant has no effect.
    serve(2'b01, 8'h5A, 8'hD8, 1'b0, 0, 0, 2'b10, 2'b10, win);
    req = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("withdrawn_no_gnt", {30'd0, gnt}, 32'd0);
    end

    // Random requests and words.
    for (int t = 0; t < 24; t++) begin
      r = 2'($urandom_range(1, 3));
      rw0 = 8'($urandom);
      rw1 = 8'($urandom);
      if (t % 4 == 0) rw0 = 8'hDB;
      serve(r, rw0, rw1, 1'b0, 0, 0, 2'b00, 2'b00, win);
      req = 2'b00;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
